// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transfer queue:
//   - default data / bit-count widths (must match the SPI master)
//   - default queue depth and no-progress timeout
//   - transfer FSM state encoding
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_REG_WIDTH     = 8;
  localparam int DEFAULT_COUNTER_WIDTH = $clog2(DEFAULT_REG_WIDTH);
  localparam int DEFAULT_DEPTH         = 4;
  localparam int DEFAULT_TIMEOUT       = 1024;

  // Transfer sequencing, one transfer in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,  // waiting for a request and RX space
    ST_START     = 3'd1,  // t_start pulse to the master
    ST_WAIT_LOW  = 3'd2,  // waiting for the master to assert cs
    ST_WAIT_HIGH = 3'd3,  // waiting for the master to release cs
    ST_CAPTURE   = 3'd4   // d_out is final, push it to the RX FIFO
  } state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_fifo.sv
// -----------------------------------------------------------------------------
// spi_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on pop_data while empty is low, so a consumer can look at it before popping.
//
// Parameters
//   WIDTH  entry width
//   DEPTH  number of entries; power of two, >= 2
// Ports
//   clk        in   1      clock, posedge
//   rst        in   1      asynchronous active-high reset (flushes pointers)
//   push       in   1      write push_data (ignored when full)
//   push_data  in   WIDTH  entry to write
//   pop        in   1      drop head entry (ignored when empty)
//   pop_data   out  WIDTH  head entry, valid while empty is low
//   full       out  1      no free entry
//   empty      out  1      no stored entry
// -----------------------------------------------------------------------------
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_en;
  logic             pop_en;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // address bits with differing wrap bits mean full.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule : spi_sync_fifo

// File: rtl/spi_xfer_queue.sv
// -----------------------------------------------------------------------------
// spi_xfer_queue
// Request/response front end for the SPI master. Host requests (data + bit
// count) are queued in a TX FIFO and issued to the master one at a time. The
// end of a transfer is recognised from cs going low then high again, after
// which the master's receive register is queued in an RX FIFO for the host.
// Zero-size requests are discarded with a pulse on err_zero; a transfer that
// makes no progress for too long is abandoned with a pulse on err_tmo.
//
// Ports
//   sys_clk    in   1                clock, posedge
//   rst        in   1                asynchronous active-high reset
//   req_valid  in   1                host request valid
//   req_ready  out  1                TX FIFO has room
//   req_data   in   REG_WIDTH        byte to shift out
//   req_size   in   COUNTER_WIDTH+1  number of bits to transfer
//   rsp_valid  out  1                RX FIFO not empty
//   rsp_ready  in   1                host takes the response
//   rsp_data   out  REG_WIDTH        oldest received byte
//   t_start    out  1                one-cycle start pulse to the master
//   d_in       out  REG_WIDTH        transmit data to the master
//   t_size     out  COUNTER_WIDTH+1  transfer size to the master
//   d_out      in   REG_WIDTH        master receive register
//   cs         in   1                master chip select, active low
//   busy       out  1                a transfer is being handled
//   err_zero   out  1                pulse: zero-size request dropped
//   err_tmo    out  1                pulse: transfer timed out
// -----------------------------------------------------------------------------
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int REG_WIDTH     = DEFAULT_REG_WIDTH,
  parameter int COUNTER_WIDTH = $clog2(REG_WIDTH),
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [REG_WIDTH-1:0]     req_data,
  input  logic [COUNTER_WIDTH:0]   req_size,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [REG_WIDTH-1:0]     rsp_data,
  output logic                     t_start,
  output logic [REG_WIDTH-1:0]     d_in,
  output logic [COUNTER_WIDTH:0]   t_size,
  input  logic [REG_WIDTH-1:0]     d_out,
  input  logic                     cs,
  output logic                     busy,
  output logic                     err_zero,
  output logic                     err_tmo
);

  localparam int SW   = COUNTER_WIDTH + 1;
  localparam int TX_W = REG_WIDTH + SW;
  localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The timer gives up on the edge where it would step to TIMEOUT-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  logic [TX_W-1:0]      tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic [REG_WIDTH-1:0] rx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;

  spi_sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data ({req_data, req_size}),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH (REG_WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (d_out),
    .pop       (rsp_ready),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign req_ready = !tx_full;
  assign rsp_valid = !rx_empty;
  // Storage is not reset, so hide the head entry while nothing is queued.
  assign rsp_data  = rx_empty ? '0 : rx_head;

  // ---------------------------------------------------------------------------
  // Issue decision
  // ---------------------------------------------------------------------------
  state_t                 state_reg;
  logic [TW-1:0]          timer_reg;
  logic [REG_WIDTH-1:0]   d_in_reg;
  logic [COUNTER_WIDTH:0] t_size_reg;
  logic                   t_start_reg;
  logic                   err_zero_reg;
  logic                   err_tmo_reg;

  logic [REG_WIDTH-1:0]   head_data;
  logic [COUNTER_WIDTH:0] head_size;
  logic                   head_zero;
  logic                   issue;
  logic                   drop;

  assign head_data = tx_head[TX_W-1:SW];
  assign head_size = tx_head[SW-1:0];
  assign head_zero = (head_size == '0);

  // A transfer only starts when its response is guaranteed a slot, so the
  // RX FIFO can never overflow. Zero-size requests are dropped regardless.
  assign issue   = (state_reg == ST_IDLE) && !tx_empty && !head_zero && !rx_full;
  assign drop    = (state_reg == ST_IDLE) && !tx_empty && head_zero;
  assign tx_pop  = issue || drop;
  assign rx_push = (state_reg == ST_CAPTURE);

  // ---------------------------------------------------------------------------
  // Transfer FSM with timer and registered master-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      d_in_reg     <= '0;
      t_size_reg   <= '0;
      t_start_reg  <= 1'b0;
      err_zero_reg <= 1'b0;
      err_tmo_reg  <= 1'b0;
    end else begin
      t_start_reg  <= 1'b0;
      err_zero_reg <= drop;
      err_tmo_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          timer_reg <= '0;
          if (issue) begin
            d_in_reg    <= head_data;
            t_size_reg  <= head_size;
            t_start_reg <= 1'b1;
            state_reg   <= ST_START;
          end
        end

        ST_START: begin
          timer_reg <= '0;
          state_reg <= ST_WAIT_LOW;
        end

        ST_WAIT_LOW: begin
          if (!cs) begin
            timer_reg <= '0;
            state_reg <= ST_WAIT_HIGH;
          end else if (timer_reg == TMO_LAST) begin
            timer_reg   <= '0;
            err_tmo_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end

        ST_WAIT_HIGH: begin
          if (cs) begin
            timer_reg <= '0;
            state_reg <= ST_CAPTURE;
          end else if (timer_reg == TMO_LAST) begin
            timer_reg   <= '0;
            err_tmo_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end

        ST_CAPTURE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          timer_reg <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign t_start  = t_start_reg;
  assign d_in     = d_in_reg;
  assign t_size   = t_size_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign err_zero = err_zero_reg;
  assign err_tmo  = err_tmo_reg;

endmodule : spi_xfer_queue

// File: tb/tb_spi_xfer_queue.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_queue
// Directed bench for spi_xfer_queue (DEPTH=4, TIMEOUT=16). A small master
// model reacts to t_start: it pulls cs low, holds it for t_size cycles, then
// loads d_out with d_in (MISO looped to MOSI) and releases cs. It can be told
// to ignore t_start so that cs stays high.
// -----------------------------------------------------------------------------
module tb_spi_xfer_queue;

  localparam int RW    = 8;
  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          sys_clk   = 1'b0;
  logic          rst       = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [RW-1:0] req_data  = '0;
  logic [CW:0]   req_size  = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_data;
  logic          t_start;
  logic [RW-1:0] d_in;
  logic [CW:0]   t_size;
  logic [RW-1:0] d_out     = '0;
  logic          cs        = 1'b1;
  logic          busy;
  logic          err_zero;
  logic          err_tmo;

  always #5 sys_clk = ~sys_clk;

  spi_xfer_queue #(
    .REG_WIDTH     (RW),
    .COUNTER_WIDTH (CW),
    .DEPTH         (DEPTH),
    .TIMEOUT       (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .t_start   (t_start),
    .d_in      (d_in),
    .t_size    (t_size),
    .d_out     (d_out),
    .cs        (cs),
    .busy      (busy),
    .err_zero  (err_zero),
    .err_tmo   (err_tmo)
  );

  int checks = 0;
  int errors = 0;

  // Event counters and master model, all evaluated on the falling edge.
  int cyc            = 0;
  int n_start        = 0;
  int n_zero         = 0;
  int n_tmo          = 0;
  int last_start_cyc = 0;
  int last_tmo_cyc   = 0;
  bit stuck          = 1'b0;
  bit m_active       = 1'b0;
  int m_cnt          = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (err_zero) n_zero++;
    if (err_tmo) begin
      n_tmo++;
      last_tmo_cyc = cyc;
    end
    if (rst) begin
      cs       = 1'b1;
      m_active = 1'b0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (t_start) begin
        n_start++;
        last_start_cyc = cyc;
        if (!stuck) begin
          m_active = 1'b1;
          m_cnt    = 0;
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt == 1) begin
        cs = 1'b0;
      end else if (m_cnt >= 1 + int'(t_size)) begin
        d_out    = d_in;
        cs       = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_req(input logic [RW-1:0] d, input logic [CW:0] s, output bit ok);
    int k = 0;
    req_valid = 1'b1;
    req_data  = d;
    req_size  = s;
    while (!req_ready && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    ok = req_ready;
    if (ok) @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_rsp(output logic [RW-1:0] d, output bit ok);
    int k = 0;
    while (!rsp_valid && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    ok = rsp_valid;
    d  = rsp_data;
    if (ok) begin
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      rsp_ready = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (t_start !== 1'b0) begin errors++; $display("FAIL reset_t_start got=%b exp=0", t_start); end
    checks++; if (d_in !== 8'h00 || t_size !== 4'd0) begin errors++; $display("FAIL reset_d_in_t_size got=%h/%0d exp=00/0", d_in, t_size); end
    checks++; if (busy !== 1'b0 || err_zero !== 1'b0 || err_tmo !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b zero=%b tmo=%b exp=0/0/0", busy, err_zero, err_tmo); end
    @(negedge sys_clk);
    $display("reset: released, outputs checked");
  endtask

  task automatic test_single();
    int s0;
    logic [RW-1:0] d;
    bit ok;
    s0 = n_start;
    req_valid = 1'b1;
    req_data  = 8'hA5;
    req_size  = 4'd8;
    @(posedge sys_clk);          // push edge N
    @(negedge sys_clk);
    req_valid = 1'b0;
    checks++; if (t_start !== 1'b0) begin errors++; $display("FAIL single_tstart_early got=%b exp=0", t_start); end
    @(negedge sys_clk);          // after edge N+1
    checks++; if (t_start !== 1'b1) begin errors++; $display("FAIL single_tstart_latency got=%b exp=1", t_start); end
    checks++; if (d_in !== 8'hA5 || t_size !== 4'd8) begin errors++; $display("FAIL single_issue got=%h/%0d exp=a5/8", d_in, t_size); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    pop_rsp(d, ok);
    checks++; if (!ok || d !== 8'hA5) begin errors++; $display("FAIL single_rsp got=%h valid=%b exp=a5", d, ok); end
    wait_cycles(20);
    checks++; if (rsp_valid !== 1'b0 || n_start - s0 != 1) begin errors++; $display("FAIL single_count got rsp_valid=%b starts=%0d exp=0/1", rsp_valid, n_start - s0); end
    $display("single: rsp=%h starts=%0d", d, n_start - s0);
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [RW-1:0] d;
    bit ok;
    bit all_ok = 1'b1;
    int s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      push_req(exp_q[i], 4'd8, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL b2b_push got=stalled exp=accepted"); end
    for (int i = 0; i < 4; i++) begin
      pop_rsp(d, ok);
      checks++; if (!ok || d !== exp_q[i]) begin errors++; $display("FAIL b2b_rsp%0d got=%h valid=%b exp=%h", i, d, ok, exp_q[i]); end
      $display("b2b: rsp%0d=%h", i, d);
    end
    wait_cycles(20);
    checks++; if (n_start - s0 != 4 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_starts got=%0d rsp_valid=%b exp=4/0", n_start - s0, rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] d;
    logic [RW-1:0] exp_d;
    bit ok;
    bit all_ok = 1'b1;
    int s0 = n_start;
    for (int i = 0; i < 6; i++) begin
      push_req(8'h51 + 8'(i), 4'd8, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL bp_push got=stalled exp=accepted"); end
    wait_cycles(100);
    checks++; if (n_start - s0 != 4) begin errors++; $display("FAIL bp_issued got=%0d exp=4", n_start - s0); end
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled got busy=%b rsp_valid=%b exp=0/1", busy, rsp_valid); end
    push_req(8'h57, 4'd8, ok);
    all_ok = ok;
    push_req(8'h58, 4'd8, ok);
    all_ok &= ok;
    checks++; if (!all_ok || req_ready !== 1'b0) begin errors++; $display("FAIL bp_tx_full got req_ready=%b pushes_ok=%b exp=0/1", req_ready, all_ok); end
    pop_rsp(d, ok);
    checks++; if (!ok || d !== 8'h51) begin errors++; $display("FAIL bp_rsp0 got=%h exp=51", d); end
    wait_cycles(30);
    checks++; if (n_start - s0 != 5) begin errors++; $display("FAIL bp_fifth got=%0d exp=5", n_start - s0); end
    for (int i = 1; i < 8; i++) begin
      exp_d = 8'h51 + 8'(i);
      pop_rsp(d, ok);
      checks++; if (!ok || d !== exp_d) begin errors++; $display("FAIL bp_rsp%0d got=%h valid=%b exp=%h", i, d, ok, exp_d); end
    end
    wait_cycles(20);
    checks++; if (n_start - s0 != 8 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got starts=%0d rsp_valid=%b exp=8/0", n_start - s0, rsp_valid); end
    $display("backpressure: starts=%0d", n_start - s0);
  endtask

  task automatic test_zero_size();
    logic [RW-1:0] d;
    bit ok;
    int s0 = n_start;
    int z0 = n_zero;
    push_req(8'h3C, 4'd8, ok);
    push_req(8'h99, 4'd0, ok);
    push_req(8'hC3, 4'd8, ok);
    pop_rsp(d, ok);
    checks++; if (!ok || d !== 8'h3C) begin errors++; $display("FAIL zero_rsp0 got=%h exp=3c", d); end
    pop_rsp(d, ok);
    checks++; if (!ok || d !== 8'hC3) begin errors++; $display("FAIL zero_rsp1 got=%h exp=c3", d); end
    wait_cycles(20);
    checks++; if (n_zero - z0 != 1) begin errors++; $display("FAIL zero_pulse got=%0d exp=1", n_zero - z0); end
    checks++; if (n_start - s0 != 2 || rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_starts got=%0d rsp_valid=%b exp=2/0", n_start - s0, rsp_valid); end
    $display("zero_size: err_zero=%0d starts=%0d", n_zero - z0, n_start - s0);
  endtask

  task automatic test_timeout();
    logic [RW-1:0] d;
    bit ok;
    int k = 0;
    int t0 = n_tmo;
    stuck = 1'b1;
    push_req(8'h77, 4'd8, ok);
    while (n_tmo == t0 && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    checks++; if (n_tmo - t0 != 1) begin errors++; $display("FAIL tmo_pulse got=%0d exp=1", n_tmo - t0); end
    checks++; if (last_tmo_cyc - last_start_cyc != 16) begin errors++; $display("FAIL tmo_delay got=%0d exp=16", last_tmo_cyc - last_start_cyc); end
    wait_cycles(5);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_state got rsp_valid=%b busy=%b exp=0/0", rsp_valid, busy); end
    stuck = 1'b0;
    push_req(8'h5A, 4'd8, ok);
    pop_rsp(d, ok);
    checks++; if (!ok || d !== 8'h5A) begin errors++; $display("FAIL tmo_next got=%h exp=5a", d); end
    checks++; if (n_tmo - t0 != 1) begin errors++; $display("FAIL tmo_extra got=%0d exp=1", n_tmo - t0); end
    $display("timeout: delay=%0d next_rsp=%h", last_tmo_cyc - last_start_cyc, d);
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int k = 0;
    int s0;
    push_req(8'hA1, 4'd8, ok);
    push_req(8'hA2, 4'd8, ok);
    push_req(8'hA3, 4'd8, ok);
    while (cs !== 1'b0 && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    @(negedge sys_clk);
    checks++; if (cs !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_inflight got cs=%b busy=%b exp=0/1", cs, busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || t_start !== 1'b0 || d_in !== 8'h00 || t_size !== 4'd0) begin errors++; $display("FAIL mid_rst_outputs got busy=%b t_start=%b d_in=%h t_size=%0d exp=0/0/00/0", busy, t_start, d_in, t_size); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL mid_rst_fifos got req_ready=%b rsp_valid=%b rsp_data=%h exp=1/0/00", req_ready, rsp_valid, rsp_data); end
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    s0 = n_start;
    wait_cycles(60);
    checks++; if (n_start != s0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got starts=%0d rsp_valid=%b busy=%b exp=0/0/0", n_start - s0, rsp_valid, busy); end
    $display("reset_midflight: starts_after=%0d rsp_valid=%b", n_start - s0, rsp_valid);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_size();
    test_timeout();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spi_xfer_queue
